// File: rtl/mem_stage_dm_pkg.sv
// Shared encodings and helpers for the MEM stage data-memory slice.
// Both the top and the lane extractor import this package.
package mem_stage_dm_pkg;

    localparam int DM_WORDS_DEF = 1024;
    localparam int BYTE_LANES   = 4;
    localparam int LANE_W       = 8;

    localparam logic [1:0] ST_SW  = 2'b00;
    localparam logic [1:0] ST_SH  = 2'b01;
    localparam logic [1:0] ST_SB  = 2'b10;
    localparam logic [1:0] ST_RSV = 2'b11;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LHU = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;

    function automatic logic storeMisaligned(input logic [1:0] st, input logic [1:0] off);
        case (st)
            ST_SW:   return off != 2'b00;
            ST_SH:   return off[0];
            default: return 1'b0;
        endcase
    endfunction

    // Undefined load encodings behave as LW, including the alignment rule.
    function automatic logic loadMisaligned(input logic [2:0] lt, input logic [1:0] off);
        case (lt)
            LD_LH, LD_LHU: return off[0];
            LD_LB, LD_LBU: return 1'b0;
            default:       return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_dm_lane_ext.sv
// Combinational lane select plus sign/zero extension of a 32-bit memory word.
// Kept separate so a future cache read path can share it.
module dm_lane_ext
    import mem_stage_dm_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  load_type_i,
    output logic [31:0] data_o
);

    logic [15:0] half;
    logic [7:0]  byteSel;

    always_comb begin
        half    = off_i[1] ? word_i[31:16] : word_i[15:0];
        byteSel = word_i[LANE_W*off_i +: LANE_W];
        data_o  = word_i;
        case (load_type_i)
            LD_LH:   data_o = {{16{half[15]}}, half};
            LD_LHU:  data_o = {16'h0000, half};
            LD_LB:   data_o = {{24{byteSel[7]}}, byteSel};
            LD_LBU:  data_o = {24'h000000, byteSel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_dm.sv
// MEM stage: data-memory access with byte-lane stores and extended loads,
// registering everything into the MEM/WB boundary.
module mem_stage_dm
    import mem_stage_dm_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEF,
    parameter int ADDR_LSB = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] AO_M,
    input  logic [31:0] WDM_M,
    input  logic [31:0] PC_M,
    input  logic [31:0] PCAdd8_M,
    input  logic [4:0]  A3_M,
    input  logic        RegWrite_M,
    input  logic        MemWrite_M,
    input  logic [1:0]  StoreType_M,
    input  logic [2:0]  LoadType_M,
    output logic [31:0] AO_W,
    output logic [31:0] DR_W,
    output logic [31:0] PC_W,
    output logic [31:0] PCAdd8_W,
    output logic [4:0]  A3_W,
    output logic        RegWrite_W,
    output logic        AdEL_W,
    output logic        AdES_W
);

    localparam int IDX_W = $clog2(DM_WORDS);

    logic [31:0] mem_q [DM_WORDS];

    logic [IDX_W-1:0]      wordIdx;
    logic [ADDR_LSB-1:0]   byteOff;
    logic [31:0]           rdWord;
    logic [31:0]           loadData_d;
    logic [31:0]           storeData;
    logic [BYTE_LANES-1:0] byteEn;
    logic [31:0]           mergedWord;
    logic                  misStore_d;
    logic                  misLoad_d;
    logic                  storeEn;

    logic [31:0] AO_q, DR_q, PC_q, PCAdd8_q;
    logic [4:0]  A3_q;
    logic        RegWrite_q, AdEL_q, AdES_q;

    // Upper address bits are ignored, so addresses wrap into the array.
    assign wordIdx = AO_M[ADDR_LSB +: IDX_W];
    assign byteOff = AO_M[ADDR_LSB-1:0];
    assign rdWord  = mem_q[wordIdx];

    dm_lane_ext u_lane_ext (
        .word_i      (rdWord),
        .off_i       (byteOff),
        .load_type_i (LoadType_M),
        .data_o      (loadData_d)
    );

    always_comb begin
        byteEn    = '0;
        storeData = WDM_M;
        case (StoreType_M)
            ST_SW: byteEn = 4'b1111;
            ST_SH: begin
                byteEn    = byteOff[1] ? 4'b1100 : 4'b0011;
                storeData = {2{WDM_M[15:0]}};
            end
            ST_SB: begin
                byteEn    = 4'b0001 << byteOff;
                storeData = {4{WDM_M[7:0]}};
            end
            default: byteEn = '0;
        endcase
    end

    always_comb begin
        mergedWord = rdWord;
        for (int b = 0; b < BYTE_LANES; b++) begin
            if (byteEn[b]) begin
                mergedWord[LANE_W*b +: LANE_W] = storeData[LANE_W*b +: LANE_W];
            end
        end
    end

    // A load is recognised as a GPR-writing instruction that does not store.
    assign misStore_d = MemWrite_M && storeMisaligned(StoreType_M, byteOff);
    assign misLoad_d  = RegWrite_M && !MemWrite_M && loadMisaligned(LoadType_M, byteOff);
    assign storeEn    = MemWrite_M && !misStore_d && (StoreType_M != ST_RSV);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (storeEn) begin
            mem_q[wordIdx] <= mergedWord;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            AO_q       <= '0;
            DR_q       <= '0;
            PC_q       <= '0;
            PCAdd8_q   <= '0;
            A3_q       <= '0;
            RegWrite_q <= 1'b0;
            AdEL_q     <= 1'b0;
            AdES_q     <= 1'b0;
        end else begin
            AO_q       <= AO_M;
            DR_q       <= loadData_d;
            PC_q       <= PC_M;
            PCAdd8_q   <= PCAdd8_M;
            A3_q       <= A3_M;
            RegWrite_q <= RegWrite_M;
            AdEL_q     <= misLoad_d;
            AdES_q     <= misStore_d;
        end
    end

    assign AO_W       = AO_q;
    assign DR_W       = DR_q;
    assign PC_W       = PC_q;
    assign PCAdd8_W   = PCAdd8_q;
    assign A3_W       = A3_q;
    assign RegWrite_W = RegWrite_q;
    assign AdEL_W     = AdEL_q;
    assign AdES_W     = AdES_q;

endmodule

// File: tb/tb_mem_stage_dm.sv
// Directed-vector bench for mem_stage_dm; each vector is one MEM-stage
// instruction whose WB-side results are compared one cycle later.
module tb_mem_stage_dm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] AO_M, WDM_M, PC_M, PCAdd8_M;
    logic [4:0]  A3_M;
    logic        RegWrite_M, MemWrite_M;
    logic [1:0]  StoreType_M;
    logic [2:0]  LoadType_M;
    logic [31:0] AO_W, DR_W, PC_W, PCAdd8_W;
    logic [4:0]  A3_W;
    logic        RegWrite_W, AdEL_W, AdES_W;

    int vectors     = 0;
    int miscompares = 0;

    mem_stage_dm dut (
        .clk         (clk),
        .reset       (reset),
        .AO_M        (AO_M),
        .WDM_M       (WDM_M),
        .PC_M        (PC_M),
        .PCAdd8_M    (PCAdd8_M),
        .A3_M        (A3_M),
        .RegWrite_M  (RegWrite_M),
        .MemWrite_M  (MemWrite_M),
        .StoreType_M (StoreType_M),
        .LoadType_M  (LoadType_M),
        .AO_W        (AO_W),
        .DR_W        (DR_W),
        .PC_W        (PC_W),
        .PCAdd8_W    (PCAdd8_W),
        .A3_W        (A3_W),
        .RegWrite_W  (RegWrite_W),
        .AdEL_W      (AdEL_W),
        .AdES_W      (AdES_W)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one MEM-stage instruction, clock it, and leave outputs settled.
    task automatic applyStimulus(input logic rst, input logic [31:0] ao, input logic [31:0] wdm,
                                 input logic [31:0] pc, input logic [31:0] pc8, input logic [4:0] a3,
                                 input logic rw, input logic mw, input logic [1:0] st,
                                 input logic [2:0] lt);
        reset       = rst;
        AO_M        = ao;
        WDM_M       = wdm;
        PC_M        = pc;
        PCAdd8_M    = pc8;
        A3_M        = a3;
        RegWrite_M  = rw;
        MemWrite_M  = mw;
        StoreType_M = st;
        LoadType_M  = lt;
        @(posedge clk);
        #1;
    endtask

    task automatic doStore(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] st);
        applyStimulus(1'b0, addr, data, 32'h0000_1000, 32'h0000_1008, 5'd0, 1'b0, 1'b1, st, 3'b000);
    endtask

    task automatic doLoad(input logic [31:0] addr, input logic [2:0] lt);
        applyStimulus(1'b0, addr, 32'h0, 32'h0000_2000, 32'h0000_2008, 5'd8, 1'b1, 1'b0, 2'b00, lt);
    endtask

    task automatic doBubble();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000);
    endtask

    initial begin
        // Reset with a live store presented: everything must read zero.
        applyStimulus(1'b1, 32'h10, 32'hFFFF_FFFF, 32'h44, 32'h4C, 5'd3, 1'b1, 1'b1, 2'b00, 3'b000);
        checkOutput("rst_AO", AO_W, 32'h0);
        checkOutput("rst_DR", DR_W, 32'h0);
        checkOutput("rst_PC", PC_W, 32'h0);
        checkOutput("rst_PC8", PCAdd8_W, 32'h0);
        checkOutput("rst_A3", {27'h0, A3_W}, 32'h0);
        checkOutput("rst_flags", {29'h0, RegWrite_W, AdEL_W, AdES_W}, 32'h0);

        doStore(32'h10, 32'h1234_5678, 2'b00);
        doLoad(32'h10, 3'b000);
        checkOutput("pre_rst_lw", DR_W, 32'h1234_5678);
        applyStimulus(1'b1, 32'h10, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 2'b00, 3'b000);
        checkOutput("rst2_DR", DR_W, 32'h0);
        doLoad(32'h10, 3'b000);
        checkOutput("post_rst_lw", DR_W, 32'h0);

        doStore(32'h20, 32'hAABB_CCDD, 2'b00);
        doStore(32'h21, 32'h0000_0011, 2'b10);
        doStore(32'h22, 32'h0000_2233, 2'b01);
        doLoad(32'h20, 3'b000);
        checkOutput("merge_lw", DR_W, 32'h2233_11DD);
        checkOutput("merge_AO", AO_W, 32'h20);
        checkOutput("merge_adel", {31'h0, AdEL_W}, 32'h0);

        doStore(32'h20, 32'hFFFF_FFFF, 2'b11);
        checkOutput("rsv_ades", {31'h0, AdES_W}, 32'h0);
        doLoad(32'h20, 3'b000);
        checkOutput("rsv_nowrite", DR_W, 32'h2233_11DD);

        doStore(32'h30, 32'h80FF_7F01, 2'b00);
        doLoad(32'h32, 3'b011);
        checkOutput("lb_32", DR_W, 32'hFFFF_FFFF);
        doLoad(32'h33, 3'b100);
        checkOutput("lbu_33", DR_W, 32'h0000_0080);
        doLoad(32'h30, 3'b001);
        checkOutput("lh_30", DR_W, 32'h0000_7F01);
        doLoad(32'h32, 3'b001);
        checkOutput("lh_32", DR_W, 32'hFFFF_80FF);
        doLoad(32'h32, 3'b010);
        checkOutput("lhu_32", DR_W, 32'h0000_80FF);
        doLoad(32'h31, 3'b011);
        checkOutput("lb_31", DR_W, 32'h0000_007F);
        doLoad(32'h30, 3'b111);
        checkOutput("ld_rsv_as_lw", DR_W, 32'h80FF_7F01);

        doStore(32'h40, 32'h5566_7788, 2'b00);
        checkOutput("sw_ok_ades", {31'h0, AdES_W}, 32'h0);
        doStore(32'h41, 32'h9999_9999, 2'b00);
        checkOutput("sw_mis_ades", {31'h0, AdES_W}, 32'h1);
        doBubble();
        checkOutput("ades_clear", {31'h0, AdES_W}, 32'h0);
        doLoad(32'h40, 3'b000);
        checkOutput("sw_mis_nowrite", DR_W, 32'h5566_7788);
        doStore(32'h43, 32'h0000_AAAA, 2'b01);
        checkOutput("sh_mis_ades", {31'h0, AdES_W}, 32'h1);
        doLoad(32'h43, 3'b001);
        checkOutput("lh_mis_adel", {31'h0, AdEL_W}, 32'h1);
        checkOutput("lh_mis_dr", DR_W, 32'h0000_5566);
        doLoad(32'h42, 3'b000);
        checkOutput("lw_mis_adel", {31'h0, AdEL_W}, 32'h1);
        doLoad(32'h43, 3'b011);
        checkOutput("lb_any_adel", {31'h0, AdEL_W}, 32'h0);
        checkOutput("lb_43", DR_W, 32'h0000_0055);

        applyStimulus(1'b0, 32'h0, 32'h0, 32'h3000, 32'h3008, 5'd5, 1'b1, 1'b0, 2'b00, 3'b000);
        checkOutput("pt_PC", PC_W, 32'h3000);
        checkOutput("pt_PC8", PCAdd8_W, 32'h3008);
        checkOutput("pt_A3", {27'h0, A3_W}, 32'd5);
        checkOutput("pt_RW", {31'h0, RegWrite_W}, 32'h1);
        doBubble();
        checkOutput("bub_PC", PC_W, 32'h0);
        checkOutput("bub_PC8", PCAdd8_W, 32'h0);
        checkOutput("bub_A3", {27'h0, A3_W}, 32'h0);
        checkOutput("bub_RW", {31'h0, RegWrite_W}, 32'h0);

        doStore(32'h0000_1004, 32'hDEAD_BEEF, 2'b00);
        doLoad(32'h0000_0004, 3'b000);
        checkOutput("wrap_lw", DR_W, 32'hDEAD_BEEF);
        checkOutput("wrap_AO", AO_W, 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
